rab_l1_slice_programmer: RTL

AXI4-Lite configuration master that programs one RAB L1 TLB slice per command: it writes the four slice registers (VA start, VA end, PA, flags) to the RAB configuration port and reports completion or failure. It sits between a control agent (host-side bridge or on-chip manager) and the RAB's AXI4-Lite configuration slave. It takes over slice-programming traffic that software otherwise issues word by word.

---
 rtl/rab_l1_slice_programmer_if.sv | 40 ++++
 rtl/rab_l1_slice_programmer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rab_l1_slice_programmer_if.sv
// AXI4-Lite bundle for the RAB configuration port.
// The master modport is the slice programmer side, the slave modport is the RAB config slave side.
interface rab_l1_slice_programmer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/rab_l1_slice_programmer.sv
// Programs one RAB L1 TLB slice (VA start, VA end, PA, flags) over AXI4-Lite per command.
// Define RAB_CFG_READBACK_EN to read all four words back and compare them after writing.
module rab_l1_slice_programmer #(
    parameter int          AW           = 32,
    parameter int          DW           = 32,
    parameter int          N_SLICES     = 16,
    parameter logic [31:0] SLICE_BASE   = 32'h20,
    parameter logic [31:0] SLICE_STRIDE = 32'h20
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      CmdValid_SI,
    output logic                      CmdReady_SO,
    input  logic [$clog2(N_SLICES):0] CmdSlice_DI,
    input  logic [AW-1:0]             CmdVaStart_DI,
    input  logic [AW-1:0]             CmdVaEnd_DI,
    input  logic [AW-1:0]             CmdPa_DI,
    input  logic [2:0]                CmdFlags_DI,
    output logic                      RspValid_SO,
    input  logic                      RspReady_SI,
    output logic [1:0]                RspCode_SO,
    output logic [1:0]                RspFailIdx_SO,
    rab_l1_slice_programmer_if.master m_axi4lite
);
    localparam int SW = $clog2(N_SLICES) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_RSP = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_RSP = 3'd4;
    localparam logic [2:0] S_RSP    = 3'd5;

    localparam logic [1:0] RSP_OK        = 2'b00;
    localparam logic [1:0] RSP_BAD_SLICE = 2'b01;
    localparam logic [1:0] RSP_BUS_ERR   = 2'b10;
    localparam logic [1:0] RSP_MISMATCH  = 2'b11;

    logic [2:0]    r_state;
    logic [SW-1:0] r_slice;
    logic [AW-1:0] r_va_start;
    logic [AW-1:0] r_va_end;
    logic [AW-1:0] r_pa;
    logic [2:0]    r_flags;
    logic [1:0]    r_k;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic [AW-1:0] r_awaddr;
    logic [DW-1:0] r_wdata;
    logic          r_rsp_valid;
    logic [1:0]    r_rsp_code;
    logic [1:0]    r_rsp_fail_idx;

    logic          w_cmd_fire;
    logic          w_bad_slice;
    logic          w_aw_fire;
    logic          w_w_fire;
    logic          w_aw_done;
    logic          w_w_done;
    logic          w_b_fire;
    logic          w_rsp_fire;
    logic [1:0]    w_next_k;

    // Word k of a slice lives at base + slice*stride + 8*k, wrapping at 2^AW.
    function automatic logic [AW-1:0] f_word_addr(input logic [SW-1:0] slice, input logic [1:0] k);
        f_word_addr = AW'(SLICE_BASE) + AW'(slice) * AW'(SLICE_STRIDE) + AW'({k, 3'b000});
    endfunction

    function automatic logic [DW-1:0] f_word_data(input logic [1:0] k);
        f_word_data = DW'(r_flags);
        case (k)
            2'd0:    f_word_data = DW'(r_va_start);
            2'd1:    f_word_data = DW'(r_va_end);
            2'd2:    f_word_data = DW'(r_pa);
            default: f_word_data = DW'(r_flags);
        endcase
    endfunction

    assign w_cmd_fire  = CmdValid_SI & CmdReady_SO;
    assign w_bad_slice = (CmdSlice_DI >= SW'(N_SLICES));
    assign w_aw_fire   = r_awvalid & m_axi4lite.awready;
    assign w_w_fire    = r_wvalid & m_axi4lite.wready;
    assign w_aw_done   = w_aw_fire | ~r_awvalid;
    assign w_w_done    = w_w_fire | ~r_wvalid;
    assign w_b_fire    = r_bready & m_axi4lite.bvalid;
    assign w_rsp_fire  = r_rsp_valid & RspReady_SI;
    assign w_next_k    = r_k + 2'd1;

`ifdef RAB_CFG_READBACK_EN
    logic          r_arvalid;
    logic [AW-1:0] r_araddr;
    logic          r_rready;
    logic          w_ar_fire;
    logic          w_r_fire;

    assign w_ar_fire = r_arvalid & m_axi4lite.arready;
    assign w_r_fire  = r_rready & m_axi4lite.rvalid;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{m_axi4lite.arready, m_axi4lite.rdata, m_axi4lite.rresp, m_axi4lite.rvalid};
`endif

    // Command sequencer: four posted writes (flags last so the slice enables only once fully
    // described), optional readback, then a held response until the agent accepts it.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state        <= S_IDLE;
            r_slice        <= '0;
            r_va_start     <= '0;
            r_va_end       <= '0;
            r_pa           <= '0;
            r_flags        <= '0;
            r_k            <= 2'd0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_awaddr       <= '0;
            r_wdata        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_code     <= RSP_OK;
            r_rsp_fail_idx <= 2'd0;
`ifdef RAB_CFG_READBACK_EN
            r_arvalid      <= 1'b0;
            r_araddr       <= '0;
            r_rready       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_slice    <= CmdSlice_DI;
                        r_va_start <= CmdVaStart_DI;
                        r_va_end   <= CmdVaEnd_DI;
                        r_pa       <= CmdPa_DI;
                        r_flags    <= CmdFlags_DI;
                        r_k        <= 2'd0;
                        if (w_bad_slice) begin
                            r_state        <= S_RSP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_code     <= RSP_BAD_SLICE;
                            r_rsp_fail_idx <= 2'd0;
                        end else begin
                            r_state   <= S_WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= f_word_addr(CmdSlice_DI, 2'd0);
                            r_wdata   <= DW'(CmdVaStart_DI);
                        end
                    end
                end

                S_WR_REQ: begin
                    if (w_aw_fire) r_awvalid <= 1'b0;
                    if (w_w_fire)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_state  <= S_WR_RSP;
                        r_bready <= 1'b1;
                    end
                end

                S_WR_RSP: begin
                    if (w_b_fire) begin
                        r_bready <= 1'b0;
                        if (m_axi4lite.bresp != 2'b00) begin
                            r_state        <= S_RSP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_code     <= RSP_BUS_ERR;
                            r_rsp_fail_idx <= r_k;
                        end else if (r_k != 2'd3) begin
                            r_k       <= w_next_k;
                            r_state   <= S_WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= f_word_addr(r_slice, w_next_k);
                            r_wdata   <= f_word_data(w_next_k);
                        end else begin
`ifdef RAB_CFG_READBACK_EN
                            r_k       <= 2'd0;
                            r_state   <= S_RD_REQ;
                            r_arvalid <= 1'b1;
                            r_araddr  <= f_word_addr(r_slice, 2'd0);
`else
                            r_state        <= S_RSP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_code     <= RSP_OK;
                            r_rsp_fail_idx <= 2'd0;
`endif
                        end
                    end
                end

`ifdef RAB_CFG_READBACK_EN
                S_RD_REQ: begin
                    if (w_ar_fire) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_RSP;
                    end
                end

                S_RD_RSP: begin
                    if (w_r_fire) begin
                        r_rready <= 1'b0;
                        if (m_axi4lite.rresp != 2'b00) begin
                            r_state        <= S_RSP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_code     <= RSP_BUS_ERR;
                            r_rsp_fail_idx <= r_k;
                        end else if (m_axi4lite.rdata != f_word_data(r_k)) begin
                            r_state        <= S_RSP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_code     <= RSP_MISMATCH;
                            r_rsp_fail_idx <= r_k;
                        end else if (r_k != 2'd3) begin
                            r_k       <= w_next_k;
                            r_state   <= S_RD_REQ;
                            r_arvalid <= 1'b1;
                            r_araddr  <= f_word_addr(r_slice, w_next_k);
                        end else begin
                            r_state        <= S_RSP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_code     <= RSP_OK;
                            r_rsp_fail_idx <= 2'd0;
                        end
                    end
                end
`else
                S_RD_REQ, S_RD_RSP: begin
                    r_state <= S_IDLE;
                end
`endif

                S_RSP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CmdReady_SO   = (r_state == S_IDLE);
    assign RspValid_SO   = r_rsp_valid;
    assign RspCode_SO    = r_rsp_code;
    assign RspFailIdx_SO = r_rsp_fail_idx;

    assign m_axi4lite.awaddr  = r_awaddr;
    assign m_axi4lite.awvalid = r_awvalid;
    assign m_axi4lite.wdata   = r_wdata;
    assign m_axi4lite.wstrb   = '1;
    assign m_axi4lite.wvalid  = r_wvalid;
    assign m_axi4lite.bready  = r_bready;

`ifdef RAB_CFG_READBACK_EN
    assign m_axi4lite.araddr  = r_araddr;
    assign m_axi4lite.arvalid = r_arvalid;
    assign m_axi4lite.rready  = r_rready;
`else
    assign m_axi4lite.araddr  = '0;
    assign m_axi4lite.arvalid = 1'b0;
    assign m_axi4lite.rready  = 1'b1;
`endif
endmodule
